// File: rtl/mat_regfile_if.sv
// Decode/writeback/transpose-control bundle for mat_regfile; master drives requests, slave returns read data and status.
interface mat_regfile_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int MROWS = 4,
   parameter int NMAT  = 2
);
   localparam int AW = $clog2(NREGS);
   localparam int MW = $clog2(NMAT);

   logic [AW-1:0]         r_regs_addr1;
   logic [AW-1:0]         r_regs_addr2;
   logic                  rs2_r_select;
   logic [MW-1:0]         r_mat_id;
   logic [1:0]            w_select;
   logic [AW-1:0]         w_regs_addr;
   logic [MW-1:0]         w_mat_id;
   logic [XLEN-1:0]       w_regs_data;
   logic [MROWS*XLEN-1:0] w_matrix_data;
   logic                  tr_start;
   logic [MW-1:0]         tr_src;
   logic [MW-1:0]         tr_dst;
   logic [XLEN-1:0]       r_regs_o1;
   logic [XLEN-1:0]       r_regs_o2;
   logic [MROWS*XLEN-1:0] r_matrix_o;
   logic                  tr_busy;
   logic                  tr_done;

   modport master (
      output r_regs_addr1, r_regs_addr2, rs2_r_select, r_mat_id, w_select, w_regs_addr,
             w_mat_id, w_regs_data, w_matrix_data, tr_start, tr_src, tr_dst,
      input  r_regs_o1, r_regs_o2, r_matrix_o, tr_busy, tr_done
   );

   modport slave (
      input  r_regs_addr1, r_regs_addr2, rs2_r_select, r_mat_id, w_select, w_regs_addr,
             w_mat_id, w_regs_data, w_matrix_data, tr_start, tr_src, tr_dst,
      output r_regs_o1, r_regs_o2, r_matrix_o, tr_busy, tr_done
   );
endinterface

// File: rtl/mat_regfile.sv
// Scalar + matrix register file with shadow-buffered transpose; reads comb, writes 1 edge, transpose MROWS+1 cycles.
// Matrix port writes are dropped while tr_busy; optional write-to-read forwarding under REGS_FWD_EN.
module mat_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int MROWS = 4,
   parameter int NMAT  = 2
) (
   input logic          clk,
   input logic          rst,
   mat_regfile_if.slave bus
);
   localparam int E  = XLEN / MROWS;
   localparam int RW = $clog2(MROWS);
   localparam int MW = $clog2(NMAT);
   localparam logic [RW-1:0] LAST_ROW = RW'(MROWS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} tr_state_e;

   tr_state_e       state_q, state_d;
   logic [RW-1:0]   k_q, k_d;
   logic [MW-1:0]   dst_q, dst_d;
   logic [XLEN-1:0] shadow_q [MROWS];
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] mat_q [NMAT][MROWS];

   logic                  capture, tr_we, busy, sc_we, row_we, mat_we;
   logic [RW-1:0]         w_row, r_row;
   logic [XLEN-1:0]       tr_row, rd1, sc2, mrow;
   logic [MROWS*XLEN-1:0] mat_rd;

   function automatic logic [XLEN-1:0] reset_row(input int r);
      logic [3:0] nib;
      case (r % 4)
         0:       nib = 4'h5;
         1:       nib = 4'hA;
         2:       nib = 4'h3;
         default: nib = 4'hC;
      endcase
      return {(XLEN / 4){nib}};
   endfunction

   assign busy   = (state_q == RUN);
   assign w_row  = bus.w_regs_addr[RW-1:0];
   assign r_row  = bus.r_regs_addr2[RW-1:0];
   assign sc_we  = (bus.w_select == 2'b01) && (bus.w_regs_addr != '0);
   assign row_we = (bus.w_select == 2'b10) && !busy;
   assign mat_we = (bus.w_select == 2'b11) && !busy;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      dst_d   = dst_q;
      capture = 1'b0;
      tr_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.tr_start) begin
               state_d = RUN;
               k_d     = '0;
               dst_d   = bus.tr_dst;
               capture = 1'b1;
            end
         end
         RUN: begin
            tr_we = 1'b1;
            k_d   = k_q + 1'b1;
            if (k_q == LAST_ROW) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Destination row k gathers element k of every shadow row.
   always_comb begin
      tr_row = '0;
      for (int c = 0; c < MROWS; c++) tr_row[c*E +: E] = shadow_q[c][k_q*E +: E];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         dst_q   <= '0;
         for (int r = 0; r < MROWS; r++) shadow_q[r] <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         for (int m = 0; m < NMAT; m++)
            for (int r = 0; r < MROWS; r++) mat_q[m][r] <= reset_row(r);
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         dst_q   <= dst_d;
         if (capture)
            for (int r = 0; r < MROWS; r++) shadow_q[r] <= mat_q[bus.tr_src][r];
         if (sc_we) regs_q[bus.w_regs_addr] <= bus.w_regs_data;
         if (row_we) mat_q[bus.w_mat_id][w_row] <= bus.w_regs_data;
         if (mat_we)
            for (int r = 0; r < MROWS; r++) mat_q[bus.w_mat_id][r] <= bus.w_matrix_data[r*XLEN +: XLEN];
         if (tr_we) mat_q[dst_q][k_q] <= tr_row;
      end
   end

   always_comb begin
      rd1    = regs_q[bus.r_regs_addr1];
      sc2    = regs_q[bus.r_regs_addr2];
      mrow   = mat_q[bus.r_mat_id][r_row];
      mat_rd = '0;
      for (int r = 0; r < MROWS; r++) mat_rd[r*XLEN +: XLEN] = mat_q[bus.r_mat_id][r];
`ifdef REGS_FWD_EN
      if (sc_we && (bus.w_regs_addr == bus.r_regs_addr1)) rd1 = bus.w_regs_data;
      if (sc_we && (bus.w_regs_addr == bus.r_regs_addr2)) sc2 = bus.w_regs_data;
      if (row_we && (bus.w_mat_id == bus.r_mat_id)) begin
         mat_rd[w_row*XLEN +: XLEN] = bus.w_regs_data;
         if (w_row == r_row) mrow = bus.w_regs_data;
      end
      if (mat_we && (bus.w_mat_id == bus.r_mat_id)) begin
         mat_rd = bus.w_matrix_data;
         mrow   = bus.w_matrix_data[r_row*XLEN +: XLEN];
      end
`endif
   end

   assign bus.r_regs_o1  = rd1;
   assign bus.r_regs_o2  = bus.rs2_r_select ? sc2 : mrow;
   assign bus.r_matrix_o = mat_rd;
   assign bus.tr_busy    = busy;
   assign bus.tr_done    = (state_q == DONE);
endmodule
